// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Exhaustive sweep-and-check stage for the 4-input F(w,x,y,z) NAND/NOR
//   circuit pair. Applies every vector 0..15 and holds each one for SETTLE
//   cycles. On the last cycle of each hold it samples both circuit responses
//   into 16-bit truth tables and compares them against EXPECTED.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   begin a sweep (sampled only in IDLE)
//   vec        out  4   applied vector {w,x,y,z}
//   f_a        in   1   response of circuit A (NAND implementation)
//   f_b        in   1   response of circuit B (NOR implementation)
//   busy       out  1   sweep in progress
//   done       out  1   one-cycle pulse at sweep completion
//   pass       out  1   zero mismatches in the last sweep (valid after done)
//   table_a    out 16   captured truth table of f_a
//   table_b    out 16   captured truth table of f_b
//   err_count  out  5   number of mismatching indices (0..16)
//   err_valid  out  1   at least one mismatch recorded
//   first_err  out  4   lowest mismatching index (valid when err_valid=1)
module truth_table_sweeper #(
    parameter int unsigned   SETTLE   = 2,
    parameter logic [15:0]   EXPECTED = 16'h1F55
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  vec,
    input  logic        f_a,
    input  logic        f_b,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] table_a,
    output logic [15:0] table_b,
    output logic [4:0]  err_count,
    output logic        err_valid,
    output logic [3:0]  first_err
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        DONE
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cnt;
    logic       sample;
    logic       mismatch;

    // Sample on the last cycle of the hold window for the current vector.
    assign sample = (state_q == APPLY) && (cnt == 4'(SETTLE - 1));

    // Case-inequality so an X/Z response in simulation counts as a mismatch.
    assign mismatch = (f_a !== EXPECTED[vec]) || (f_b !== EXPECTED[vec]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                busy = 1'b1;
                if (sample && (vec == 4'd15)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec       <= '0;
            cnt       <= '0;
            table_a   <= '0;
            table_b   <= '0;
            err_count <= '0;
            err_valid <= 1'b0;
            first_err <= '0;
            pass      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        vec       <= '0;
                        cnt       <= '0;
                        table_a   <= '0;
                        table_b   <= '0;
                        err_count <= '0;
                        err_valid <= 1'b0;
                        first_err <= '0;
                        pass      <= 1'b0;
                    end
                end
                APPLY: begin
                    if (sample) begin
                        table_a[vec] <= f_a;
                        table_b[vec] <= f_b;
                        if (mismatch) begin
                            err_count <= err_count + 5'd1;
                            if (!err_valid) begin
                                first_err <= vec;
                                err_valid <= 1'b1;
                            end
                        end
                        // vec parks at 15 once the sweep finishes.
                        if (vec != 4'd15) begin
                            vec <= vec + 4'd1;
                        end
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    pass <= (err_count == '0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

    localparam logic [15:0] GOLD = 16'h1F55;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  vec;
    logic        f_a;
    logic        f_b;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] table_a;
    logic [15:0] table_b;
    logic [4:0]  err_count;
    logic        err_valid;
    logic [3:0]  first_err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int mode = 0;   // 0 golden, 1 f_b stuck-1 at vec 12/13, 2 both inverted

    typedef struct {
        logic [15:0] ta;
        logic [15:0] tb;
        logic [4:0]  ec;
        logic        ev;
        logic [3:0]  fe;
        logic        ps;
        int          e0;
    } exp_t;

    exp_t sb[$];

    truth_table_sweeper #(
        .SETTLE(2),
        .EXPECTED(GOLD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .vec(vec),
        .f_a(f_a),
        .f_b(f_b),
        .busy(busy),
        .done(done),
        .pass(pass),
        .table_a(table_a),
        .table_b(table_b),
        .err_count(err_count),
        .err_valid(err_valid),
        .first_err(first_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Circuit models driven from the applied vector.
    always_comb begin
        f_a = GOLD[vec];
        f_b = GOLD[vec];
        if (mode == 1) begin
            if (vec == 4'd12 || vec == 4'd13) f_b = 1'b1;
        end else if (mode == 2) begin
            f_a = ~GOLD[vec];
            f_b = ~GOLD[vec];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares results whenever done is presented.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_latency", 32'(cyc - e.e0), 32'd32);
                    chk("busy_in_done", {31'd0, busy}, 32'd0);
                    chk("table_a", {16'd0, table_a}, {16'd0, e.ta});
                    chk("table_b", {16'd0, table_b}, {16'd0, e.tb});
                    chk("err_count", {27'd0, err_count}, {27'd0, e.ec});
                    chk("err_valid", {31'd0, err_valid}, {31'd0, e.ev});
                    chk("first_err", {28'd0, first_err}, {28'd0, e.fe});
                    chk("vec_end", {28'd0, vec}, 32'd15);
                    @(negedge clk);
                    chk("done_one_cycle", {31'd0, done}, 32'd0);
                    chk("pass", {31'd0, pass}, {31'd0, e.ps});
                end
            end
        end
    end

    task automatic run_sweep(input int m, input exp_t e, input int restart_at);
        int bc;
        exp_t x;
        x = e;
        bc = 0;
        mode = m;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        x.e0 = cyc;
        sb.push_back(x);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = (k == restart_at);
            if (busy === 1'b1) bc++;
        end
        start = 1'b0;
        chk("busy_cycles", 32'(bc), 32'd32);
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        exp_t e;
        int   waited;

        // 1: reset then idle
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_vec", {28'd0, vec}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pass", {31'd0, pass}, 32'd0);
        chk("rst_err_count", {27'd0, err_count}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_vec", {28'd0, vec}, 32'd0);

        // 2: golden sweep
        e = '{ta: 16'h1F55, tb: 16'h1F55, ec: 5'd0, ev: 1'b0, fe: 4'd0, ps: 1'b1, e0: 0};
        run_sweep(0, e, 0);

        // 3: f_b stuck at 1 on vectors 12 and 13; only 13 differs from golden
        e = '{ta: 16'h1F55, tb: 16'h3F55, ec: 5'd1, ev: 1'b1, fe: 4'd13, ps: 1'b0, e0: 0};
        run_sweep(1, e, 0);

        // 4: both circuits inverted -> every index mismatches
        e = '{ta: 16'hE0AA, tb: 16'hE0AA, ec: 5'd16, ev: 1'b1, fe: 4'd0, ps: 1'b0, e0: 0};
        run_sweep(2, e, 0);

        // 5: start re-asserted mid-sweep is ignored
        e = '{ta: 16'h1F55, tb: 16'h1F55, ec: 5'd0, ev: 1'b0, fe: 4'd0, ps: 1'b1, e0: 0};
        run_sweep(0, e, 10);

        // 6: reset mid-sweep, then a clean sweep
        mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (vec !== 4'd7 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("reach_vec7", {28'd0, vec}, 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("abort_vec", {28'd0, vec}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_err_count", {27'd0, err_count}, 32'd0);
        chk("abort_err_valid", {31'd0, err_valid}, 32'd0);
        chk("abort_table_a", {16'd0, table_a}, 32'd0);
        chk("abort_table_b", {16'd0, table_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        e = '{ta: 16'h1F55, tb: 16'h1F55, ec: 5'd0, ev: 1'b0, fe: 4'd0, ps: 1'b1, e0: 0};
        run_sweep(0, e, 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
